// File: rtl/dist_fmt_pkg.sv
// Shared types and constants for the distance-to-ASCII formatter.
// Frame layout: five digits, space, "cm", CR, LF.
package dist_fmt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_SEND = 2'd2
   } fmt_state_e;

   localparam int unsigned FRAME_LEN = 10;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned BCD_W     = 20;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_C     = 8'h63;
   localparam logic [7:0] ASCII_M     = 8'h6D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   // Byte at position idx of the frame; lz marks a digit preceded only by zeros.
   function automatic logic [7:0] frame_byte(input logic [BCD_W-1:0] bcd,
                                             input logic [IDX_W-1:0] idx,
                                             input logic             blank);
      logic [3:0] d;
      logic       lz;
      logic [7:0] b;
      d  = 4'd0;
      lz = 1'b0;
      b  = 8'h00;
      case (idx)
         4'd0: begin d = bcd[19:16]; lz = (bcd[19:16] == 4'd0);  end
         4'd1: begin d = bcd[15:12]; lz = (bcd[19:12] == 8'd0);  end
         4'd2: begin d = bcd[11:8];  lz = (bcd[19:8]  == 12'd0); end
         4'd3: begin d = bcd[7:4];   lz = (bcd[19:4]  == 16'd0); end
         4'd4: begin d = bcd[3:0];   lz = 1'b0;                  end
         default: ;
      endcase
      case (idx)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4:
            b = (blank && lz) ? ASCII_SPACE : ASCII_ZERO + {4'd0, d};
         4'd5: b = ASCII_SPACE;
         4'd6: b = ASCII_C;
         4'd7: b = ASCII_M;
         4'd8: b = ASCII_CR;
         4'd9: b = ASCII_LF;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/bin2bcd16.sv
// Iterative 16-bit double-dabble: one add-3/shift step per cycle after start.
// done and bcd are the outcome of the step being applied this cycle (the 16th).
module bin2bcd16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        done,
   output logic [19:0] bcd
);

   localparam int unsigned BIN_W  = 16;
   localparam int unsigned BCD_W  = 20;
   localparam int unsigned ITER_W = 4;

   // Before its last shift the top digit is at most 3 (65535 < 100000), so 19 bits suffice.
   logic [BCD_W-2:0]  acc_q, acc_d, adj;
   logic [BIN_W-1:0]  bin_q, bin_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              run_q, run_d;
   logic [BCD_W-1:0]  step;

   // One double-dabble step on the current accumulator.
   always_comb begin
      adj = acc_q;
      for (int i = 0; i < 4; i++) begin
         if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         end
      end
      step = {adj, bin_q[BIN_W-1]};
   end

   always_comb begin
      acc_d  = acc_q;
      bin_d  = bin_q;
      iter_d = iter_q;
      run_d  = run_q;
      if (start) begin
         acc_d  = '0;
         bin_d  = bin;
         iter_d = '0;
         run_d  = 1'b1;
      end else if (run_q) begin
         acc_d  = step[BCD_W-2:0];
         bin_d  = {bin_q[BIN_W-2:0], 1'b0};
         iter_d = iter_q + ITER_W'(1);
         if (iter_q == ITER_W'(BIN_W - 1)) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         bin_q  <= '0;
         iter_q <= '0;
         run_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         bin_q  <= bin_d;
         iter_q <= iter_d;
         run_q  <= run_d;
      end
   end

   assign done = run_q && (iter_q == ITER_W'(BIN_W - 1));
   assign bcd  = step;

endmodule

// File: rtl/dist_ascii_fmt.sv
// Samples distance once per report period and streams "DDDDD cm\r\n" over valid/ready.
// FMT_BLANK_ZERO_EN: leading zero digits (except units) are sent as spaces.
module dist_ascii_fmt
   import dist_fmt_pkg::*;
#(
   parameter int unsigned REPORT_CYC = 10_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy
);

   localparam int unsigned CNT_W = 32;
`ifdef FMT_BLANK_ZERO_EN
   localparam logic BLANK_ZERO = 1'b1;
`else
   localparam logic BLANK_ZERO = 1'b0;
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;
   fmt_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
   logic [BCD_W-1:0] digits_q, digits_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_valid_q, tx_valid_d;
   logic             busy_q, busy_d;
   logic             conv_start, conv_done;
   logic [BCD_W-1:0] conv_bcd;

   // Free-running report period counter; ticks are ignored outside IDLE.
   assign tick       = (cnt_q == CNT_W'(REPORT_CYC - 1));
   assign cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
   assign conv_start = (state_q == ST_IDLE) && tick;
   assign idx_nxt    = idx_q + IDX_W'(1);

   bin2bcd16 u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .bin   (data),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      digits_d   = digits_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               state_d = ST_CONV;
               busy_d  = 1'b1;
            end
         end
         ST_CONV: begin
            if (conv_done) begin
               state_d    = ST_SEND;
               digits_d   = conv_bcd;
               idx_d      = '0;
               tx_valid_d = 1'b1;
               tx_data_d  = frame_byte(conv_bcd, '0, BLANK_ZERO);
            end
         end
         ST_SEND: begin
            if (tx_ready) begin
               if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                  state_d    = ST_IDLE;
                  idx_d      = '0;
                  tx_valid_d = 1'b0;
                  tx_data_d  = 8'h00;
                  busy_d     = 1'b0;
               end else begin
                  idx_d     = idx_nxt;
                  tx_data_d = frame_byte(digits_q, idx_nxt, BLANK_ZERO);
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         digits_q   <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
         digits_q   <= digits_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_dist_ascii_fmt.sv
// Randomized bench for dist_ascii_fmt with a cycle-level behavioural model and frame literals.
module tb_dist_ascii_fmt;

   localparam int unsigned N = 32;
`ifdef FMT_BLANK_ZERO_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   int errors = 0;
   int checks = 0;

   dist_ascii_fmt #(.REPORT_CYC(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data     (data),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic string lit(input string digits);
      return {digits, " cm\015\012"};
   endfunction

   // Expected frame text straight from the decimal value.
   function automatic string fmt(input int unsigned v);
      string       s;
      int unsigned div;
      bit          lead;
      s    = "00000";
      div  = 10000;
      for (int i = 0; i < 5; i++) begin
         s[i] = 8'(32'h30 + (v / div) % 10);
         div  = div / 10;
      end
      lead = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (BLANK && lead && s[i] == 8'h30) s[i] = 8'h20;
         else lead = 1'b0;
      end
      return lit(s);
   endfunction

   // Behavioural model: edge k after reset release samples a tick when k is a multiple of N.
   int          edge_no;
   bit          m_busy, m_send;
   int          m_pos, m_end;
   int unsigned m_lat;
   string       m_frame;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_no = 0;
         m_busy  = 1'b0;
         m_send  = 1'b0;
         m_pos   = 0;
         m_end   = 0;
      end else begin
         edge_no++;
         if (!m_busy) begin
            if (edge_no % N == 0) begin
               m_lat  = data;
               m_end  = edge_no + 16;
               m_busy = 1'b1;
            end
         end else if (!m_send) begin
            if (edge_no == m_end) begin
               m_frame = fmt(m_lat);
               m_send  = 1'b1;
               m_pos   = 0;
            end
         end else if (tx_ready) begin
            m_pos++;
            if (m_pos == 10) begin
               m_send = 1'b0;
               m_busy = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("tx_valid", 32'(tx_valid), 32'(m_send));
         check("busy", 32'(busy), 32'(m_busy));
         if (m_send) check("tx_data", 32'(tx_data), 32'(m_frame[m_pos]));
      end
   end

   logic [7:0] rx[$];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx.delete();
      else if (tx_valid && tx_ready) rx.push_back(tx_data);
   end

   // mode 0: ready high; 1: random ready with 5-cycle stall at byte 2;
   // 2: data changes right after latch; 3: 40-cycle stall at byte 3.
   task automatic run_frame(input int unsigned val, input int mode, input string exp, input string name);
      int    stall   = 0;
      bit    changed = 1'b0;
      bit    ok      = 1'b1;
      string act     = "";
      string exph    = "";
      data = 16'(val);
      rx.delete();
      for (int c = 0; c < 800 && rx.size() < 10; c++) begin
         @(negedge clk);
         case (mode)
            1: begin
               if (tx_valid && rx.size() == 2 && stall < 5) begin
                  tx_ready = 1'b0;
                  stall++;
               end else begin
                  tx_ready = 1'($urandom_range(0, 1));
               end
            end
            2: begin
               tx_ready = 1'b1;
               if (busy && !changed) begin
                  data    = 16'd200;
                  changed = 1'b1;
               end
            end
            3: begin
               if (tx_valid && rx.size() == 3 && stall < 40) begin
                  tx_ready = 1'b0;
                  stall++;
               end else begin
                  tx_ready = 1'b1;
               end
            end
            default: tx_ready = 1'b1;
         endcase
      end
      checks++;
      if (rx.size() != 10) begin
         errors++;
         $display("FAIL %s: received %0d bytes expected 10", name, rx.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            act  = {act, $sformatf("%02h ", rx[i])};
            exph = {exph, $sformatf("%02h ", exp[i])};
            if (rx[i] !== exp[i]) ok = 1'b0;
         end
         if (!ok) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, act, exph);
         end
      end
   endtask

   initial begin
      int k;
      int unsigned v;
      rst_n    = 1'b0;
      data     = 16'd0;
      tx_ready = 1'b1;
      #12;
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'h00);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_frame(1234, 0, BLANK ? lit(" 1234") : lit("01234"), "basic");
      run_frame(65535, 0, lit("65535"), "max");
      run_frame(0, 0, BLANK ? lit("    0") : lit("00000"), "zero");
      run_frame(42, 1, BLANK ? lit("   42") : lit("00042"), "backpressure");
      run_frame(100, 2, BLANK ? lit("  100") : lit("00100"), "data_change");
      run_frame(200, 0, BLANK ? lit("  200") : lit("00200"), "data_next");
      run_frame(9, 3, BLANK ? lit("    9") : lit("00009"), "dropped_tick");
      run_frame(31415, 0, lit("31415"), "after_drop");
      for (int i = 0; i < 4; i++) begin
         v = $urandom_range(0, 65535);
         run_frame(v, 1, fmt(v), "random");
      end

      // Reset while byte 4 is on the bus.
      data     = 16'd777;
      tx_ready = 1'b1;
      rx.delete();
      k = 0;
      while (k < 300 && !(tx_valid && rx.size() == 4)) begin
         @(negedge clk);
         k++;
      end
      check("reach_byte4", 32'(rx.size()), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tx_valid", 32'(tx_valid), 32'd0);
      check("midrst_tx_data", 32'(tx_data), 32'h00);
      check("midrst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      while (k < 300) begin
         @(negedge clk);
         k++;
         if (tx_valid) break;
      end
      check("restart_latency", 32'(k), 32'(N + 16));
      run_frame(777, 0, BLANK ? lit("  777") : lit("00777"), "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
